scan_loader: RTL and testbench
==============================

SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64: total configuration bits in the target scan chain (>=1).
REQ-002 Parameter DW, default 8: host word width in bits (>=1).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, synchronous and active-low.
REQ-005 START  input  1  one-cycle request to begin a full chain load.
REQ-006 ABORT  input  1  cancels an in-progress load.
REQ-007 DIN  input  DW  configuration word from host, LSB shifted first.
REQ-008 DIN_VALID  input  1  DIN holds a valid word.
REQ-009 DIN_READY  output  1  loader accepts DIN this cycle.
REQ-010 SCAN_CE  output  1  chain shift enable; chain shifts on every CLK edge where it is 1.
REQ-011 SCAN_SIN  output  1  serial data into chain head.
REQ-012 SCAN_SOUT  input  1  serial data from chain tail.
REQ-013 BUSY  output  1  load in progress.
REQ-014 DONE  output  1  one-cycle pulse on successful completion.
REQ-015 RB_DATA  output  DW  readback word of previous chain contents.
REQ-016 RB_VALID  output  1  one-cycle qualifier for RB_DATA; no backpressure.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, SHIFT, FINISH.
REQ-018 IDLE: START=1 -> WAIT, clear bit counter and readback accumulator; otherwise stay.
REQ-019 WAIT: DIN_READY=1; on DIN_VALID&DIN_READY latch DIN, go to SHIFT next cycle.
REQ-020 SHIFT: SCAN_CE=1 for n=min(DW, CHAIN_LEN-bits_shifted) consecutive cycles, SCAN_SIN = latched word bit k on the k-th cycle (k=0..n-1).
REQ-021 SCAN_CE and SCAN_SIN SHALL be registered outputs; no shift cycle SHALL occur outside SHIFT.
REQ-022 After a word's n bits: bits_shifted<CHAIN_LEN -> WAIT; bits_shifted=CHAIN_LEN -> FINISH; unused high bits of final word discarded.
REQ-023 FINISH: DONE=1 for exactly one cycle, then IDLE.
REQ-024 BUSY=1 in WAIT, SHIFT, FINISH; 0 in IDLE.
REQ-025 DIN_READY=0 in IDLE, SHIFT, FINISH; words offered then are not consumed.
REQ-026 Bit counter width SHALL be clog2(CHAIN_LEN+1); no wrap permitted; never exceeds CHAIN_LEN.
REQ-027 Readback: on each edge where SCAN_CE=1, SCAN_SOUT SHALL be captured into accumulator bit position (bits_shifted mod DW).
REQ-028 RB_VALID SHALL pulse the cycle after every DW-th captured bit and after the final captured bit; unfilled high bits of a partial final word SHALL be 0.
REQ-029 START while BUSY=1 SHALL be ignored.
REQ-030 ABORT=1 in any non-IDLE state -> IDLE next cycle; SCAN_CE=0 from that cycle; no DONE; no further RB_VALID.
REQ-031 ABORT and START same cycle in IDLE: ABORT wins, stay IDLE.
REQ-032 WAIT with DIN_VALID=0 SHALL hold indefinitely with SCAN_CE=0 (chain state preserved).

Reset
REQ-033 RST_N=0 at a rising edge SHALL force IDLE, counters and accumulator 0, all outputs 0 the next cycle, regardless of state (mid-shift included).
REQ-034 Reset has priority over START and ABORT.

Verification
REQ-035 CHAIN_LEN=20, DW=8, words 0xA5,0x3C,0x0F with DIN_VALID held -> exactly 20 SCAN_CE cycles, SIN sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; DONE pulses once; BUSY low after.
REQ-036 Same load with chain model preloaded to all-1 -> RB_DATA 0xFF, 0xFF, 0x0F with three RB_VALID pulses.
REQ-037 DIN_VALID deasserted 10 cycles between words -> SCAN_CE=0 throughout gap, final chain contents identical to REQ-035.
REQ-038 ABORT asserted on 5th shift cycle of word 2 -> SCAN_CE low next cycle, no DONE, IDLE; subsequent START performs full 20-bit load.
REQ-039 RST_N low for one edge during SHIFT -> all outputs 0 next cycle, state IDLE; START during BUSY in a separate run ignored (total SCAN_CE cycles stays 20).

Source files
------------

// File: rtl/scan_loader.sv
// Scan-chain configuration loader: host words are shifted LSB-first into a serial
// chain while the previous chain contents are captured and returned as readback words.
module scan_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int DW        = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [DW-1:0] din_i,
  input  logic          din_valid_i,
  output logic          din_ready_o,
  output logic          scan_ce_o,
  output logic          scan_sin_o,
  input  logic          scan_sout_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] rb_data_o,
  output logic          rb_valid_o
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SHIFT,
    ST_FINISH
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   bits_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_d;
  logic [DW-1:0]   word_q;
  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   acc_d;
  logic            din_ready_q;
  logic            scan_ce_q;
  logic            scan_sin_q;
  logic            busy_q;
  logic            done_q;
  logic [DW-1:0]   rb_data_q;
  logic            rb_valid_q;
  logic            word_last;
  logic            chain_last;

  // The accumulator is cleared at every word start, so bits above idx_q are
  // already 0 and a short final word reads back zero-padded.
  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = scan_sout_i;
    idx_d        = idx_q + IW'(1);
    chain_last   = (bits_q == LAST_BIT);
    word_last    = (idx_q == LAST_IDX) || chain_last;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      bits_q      <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      acc_q       <= '0;
      din_ready_q <= 1'b0;
      scan_ce_q   <= 1'b0;
      scan_sin_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      din_ready_q <= 1'b0;
      scan_ce_q   <= 1'b0;
      scan_sin_q  <= 1'b0;
      done_q      <= 1'b0;
      rb_valid_q  <= 1'b0;

      // The chain shifts on every edge where scan_ce was high, abort edge included.
      if (scan_ce_q) begin
        acc_q  <= acc_d;
        bits_q <= bits_q + CW'(1);
        idx_q  <= idx_d;
      end

      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (start_i && !abort_i) begin
            state_q     <= ST_WAIT;
            bits_q      <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b1;
            din_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (din_valid_i && din_ready_q) begin
            word_q     <= din_i;
            idx_q      <= '0;
            acc_q      <= '0;
            state_q    <= ST_SHIFT;
            scan_ce_q  <= 1'b1;
            scan_sin_q <= din_i[0];
          end else begin
            din_ready_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (word_last) begin
            rb_valid_q <= 1'b1;
            rb_data_q  <= acc_d;
            if (chain_last) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_WAIT;
              din_ready_q <= 1'b1;
            end
          end else begin
            scan_ce_q  <= 1'b1;
            scan_sin_q <= word_q[idx_d];
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready_o = din_ready_q;
  assign scan_ce_o   = scan_ce_q;
  assign scan_sin_o  = scan_sin_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rb_data_o   = rb_data_q;
  assign rb_valid_o  = rb_valid_q;

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader (CHAIN_LEN=20, DW=8) with a behavioural 20-bit chain model.
module tb_scan_loader;

  localparam int CL = 20;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         scan_ce;
  logic         scan_sin;
  logic         scan_sout;
  logic         busy;
  logic         done;
  logic [W-1:0] rb_data;
  logic         rb_valid;

  always #5 clk = ~clk;

  scan_loader #(.CHAIN_LEN(CL), .DW(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .din_i       (din),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready),
    .scan_ce_o   (scan_ce),
    .scan_sin_o  (scan_sin),
    .scan_sout_i (scan_sout),
    .busy_o      (busy),
    .done_o      (done),
    .rb_data_o   (rb_data),
    .rb_valid_o  (rb_valid)
  );

  // Chain model and event recorders
  logic [CL-1:0] chain;
  logic [CL-1:0] preload;
  logic          clr;
  int            ce_cnt;
  int            rb_cnt;
  int            done_cnt;
  logic [31:0]   sin_log;
  logic [W-1:0]  rb_log [4];

  assign scan_sout = chain[CL-1];

  always @(posedge clk) begin
    if (clr) begin
      chain    <= preload;
      ce_cnt   <= 0;
      rb_cnt   <= 0;
      done_cnt <= 0;
      sin_log  <= '0;
      for (int i = 0; i < 4; i++) rb_log[i] <= '0;
    end else begin
      if (scan_ce) begin
        chain <= {chain[CL-2:0], scan_sin};
        if (ce_cnt < 32) sin_log[ce_cnt] <= scan_sin;
        ce_cnt <= ce_cnt + 1;
      end
      if (rb_valid) begin
        if (rb_cnt < 4) rb_log[rb_cnt] <= rb_data;
        rb_cnt <= rb_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] words [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_run(input logic [CL-1:0] p);
    preload = p;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int t;
    din = w;
    din_valid = 1'b1;
    t = 0;
    while (!din_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("din_ready_wait", (t < 100), 1);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!din_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_state_reached", (t < 100), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", (t < 200), 1);
  endtask

  task automatic full_load(input bit gap);
    int snap;
    pulse_start();
    for (int w = 0; w < 3; w++) begin
      send_word(words[w]);
      if (gap && w < 2) begin
        din_valid = 1'b0;
        wait_ready();
        snap = ce_cnt;
        repeat (10) @(negedge clk);
        chk("gap_no_shift", ce_cnt, snap);
        chk("gap_ready_held", din_ready, 1);
      end
    end
    din_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int t;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'h0F;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; din = '0; din_valid = 1'b0;
    preload = '0; clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_ce", scan_ce, 0);
    chk("rst_done", done, 0);
    chk("rst_rbv", rb_valid, 0);
    chk("rst_rbd", rb_data, 0);
    rst_n = 1'b1;
    clr = 1'b0;
    @(negedge clk);
    chk("idle_ready", din_ready, 0);

    // Full load, data held valid, chain preloaded with ones
    clear_run(20'hFFFFF);
    full_load(1'b0);
    chk("a_ce_count", ce_cnt, 20);
    chk("a_sin_seq", sin_log, 32'h000F3CA5);
    chk("a_done_count", done_cnt, 1);
    chk("a_busy_low", busy, 0);
    chk("a_done_low", done, 0);
    chk("a_chain", chain, 20'hA53CF);
    chk("a_rb_count", rb_cnt, 3);
    chk("a_rb0", rb_log[0], 8'hFF);
    chk("a_rb1", rb_log[1], 8'hFF);
    chk("a_rb2", rb_log[2], 8'h0F);

    // Gaps between words, chain preloaded with a pattern
    clear_run(20'h12345);
    full_load(1'b1);
    chk("b_ce_count", ce_cnt, 20);
    chk("b_chain", chain, 20'hA53CF);
    chk("b_done_count", done_cnt, 1);
    chk("b_rb_count", rb_cnt, 3);
    chk("b_rb0", rb_log[0], 8'h48);
    chk("b_rb1", rb_log[1], 8'h2C);
    chk("b_rb2", rb_log[2], 8'h0A);

    // Abort on the 5th shift of word 2
    clear_run('0);
    pulse_start();
    send_word(words[0]);
    send_word(words[1]);
    t = 0;
    while (!(scan_ce && ce_cnt == 12) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("c_reach_5th", (t < 50), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    din_valid = 1'b0;
    chk("c_ce_low", scan_ce, 0);
    chk("c_busy_low", busy, 0);
    repeat (5) @(negedge clk);
    chk("c_ce_count", ce_cnt, 13);
    chk("c_no_done", done_cnt, 0);
    chk("c_rb_count", rb_cnt, 1);
    chk("c_still_idle", busy, 0);
    clear_run('0);
    full_load(1'b0);
    chk("c2_ce_count", ce_cnt, 20);
    chk("c2_chain", chain, 20'hA53CF);
    chk("c2_done_count", done_cnt, 1);

    // Abort and start together in idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("d_abort_wins", busy, 0);
    chk("d_ready_low", din_ready, 0);

    // Reset mid-shift
    clear_run('0);
    pulse_start();
    send_word(words[0]);
    @(negedge clk);
    chk("e_in_shift", scan_ce, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    din_valid = 1'b0;
    chk("e_ce", scan_ce, 0);
    chk("e_sin", scan_sin, 0);
    chk("e_busy", busy, 0);
    chk("e_ready", din_ready, 0);
    chk("e_done", done, 0);
    chk("e_rbv", rb_valid, 0);
    @(negedge clk);
    chk("e_stays_idle", busy, 0);

    // START while busy is ignored
    clear_run('0);
    pulse_start();
    pulse_start();
    send_word(words[0]);
    pulse_start();
    send_word(words[1]);
    send_word(words[2]);
    pulse_start();
    din_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("f_ce_count", ce_cnt, 20);
    chk("f_done_count", done_cnt, 1);
    chk("f_chain", chain, 20'hA53CF);
    chk("f_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
